// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: same-cycle hit lookup,
// single-word refill on a miss, saturating hit/miss counters.
module icache #(
   parameter int SETS = 16,
   parameter int TAGW = 30 - $clog2(SETS)
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        flush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic        state_dbg
);
   localparam int IW = $clog2(SETS);

   // Handshake: iREN high requests the word at iaddr; the cycle in which
   // iwait is low while iREN is high carries valid iload, sampled at that edge.
   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

   state_t state, next_state;

   logic [SETS-1:0] valid;
   logic [TAGW-1:0] tags [SETS];
   logic [31:0]     words [SETS];

   logic [IW-1:0]   idx;
   logic [TAGW-1:0] tag_in;
   logic            hit;
   logic            fill;
   logic            miss_start;
   logic            unused_addr_bits;

   assign idx              = imemaddr[IW+1:2];
   assign tag_in           = imemaddr[31:IW+2];
   assign hit              = imemREN & valid[idx] & (tags[idx] == tag_in);
   assign iaddr            = {imemaddr[31:2], 2'b00};
   assign state_dbg        = state;
   assign unused_addr_bits = ^imemaddr[1:0];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      ihit       = 1'b0;
      imemload   = 32'h0;
      iREN       = 1'b0;
      fill       = 1'b0;
      miss_start = 1'b0;
      case (state)
         IDLE: begin
            ihit     = hit & ~flush;
            imemload = ihit ? words[idx] : 32'h0;
            if (imemREN && !hit && !flush) begin
               next_state = FETCH;
               miss_start = 1'b1;
            end
         end
         FETCH: begin
            // A dropped request abandons the refill without writing a frame.
            if (imemREN) begin
               iREN = 1'b1;
               if (!iwait) begin
                  fill       = 1'b1;
                  next_state = IDLE;
               end
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (flush) begin
         next_state = IDLE;
      end
   end

   // Only the valid bits need reset; flush wins over a same-edge fill.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (fill) begin
         valid[idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (fill && !flush) begin
         tags[idx]  <= tag_in;
         words[idx] <= iload;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= 32'h0;
         miss_count <= 32'h0;
      end else begin
         if (state == IDLE && ihit && hit_count != 32'hFFFF_FFFF) begin
            hit_count <= hit_count + 32'd1;
         end
         if (miss_start && miss_count != 32'hFFFF_FFFF) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: fills, hits, conflicts, redirect, flush and
// reset, with a simple address-derived memory model behind the cache.
module tb_icache;
   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        flush;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   logic        state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   icache dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
      .iaddr(iaddr), .iwait(iwait), .iload(iload), .hit_count(hit_count),
      .miss_count(miss_count), .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h2001_0005 + (a << 4);
   endfunction

   assign iload = mem_word(iaddr);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Resets the DUT; returns at a falling edge with nRST released.
   task automatic do_reset();
      imemREN  = 1'b0;
      imemaddr = 32'h0;
      flush    = 1'b0;
      iwait    = 1'b1;
      nRST     = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   // Starts at a falling edge. A hit consumes one clock edge; a miss walks
   // the refill and returns on the falling edge where the lookup hits again,
   // without letting that hit reach a clock edge.
   task automatic access(input logic [31:0] a, input int waits, input logic exp_hit, input string tag);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      #1;
      check({tag, "_hit"}, {31'h0, ihit}, {31'h0, exp_hit});
      if (ihit) begin
         check({tag, "_hitdata"}, imemload, mem_word(a));
         @(negedge CLK);
      end else begin
         check({tag, "_missload"}, imemload, 32'h0);
         @(negedge CLK);
         for (int n = 0; n <= waits; n++) begin
            iwait = (n < waits);
            #1;
            check({tag, "_iren"}, {31'h0, iREN}, 32'h1);
            check({tag, "_iaddr"}, iaddr, {a[31:2], 2'b00});
            check({tag, "_noihit"}, {31'h0, ihit}, 32'h0);
            @(negedge CLK);
         end
         iwait = 1'b1;
         #1;
         check({tag, "_fillhit"}, {31'h0, ihit}, 32'h1);
         check({tag, "_filldata"}, imemload, mem_word(a));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      // Reset state, observed before release as well as after.
      nRST = 1'b0;
      #1;
      check("rst_ihit", {31'h0, ihit}, 32'h0);
      check("rst_iren", {31'h0, iREN}, 32'h0);
      check("rst_load", imemload, 32'h0);
      check("rst_hits", hit_count, 32'h0);
      check("rst_miss", miss_count, 32'h0);
      check("rst_state", {31'h0, state_dbg}, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;

      // First miss: fill with iwait low on the first FETCH cycle.
      access(32'h0, 0, 1'b0, "first");
      check("first_miss_cnt", miss_count, 32'd1);
      check("first_hit_cnt0", hit_count, 32'd0);
      check("first_word", imemload, 32'h2001_0005);
      @(negedge CLK);
      #1;
      check("first_hit_cnt1", hit_count, 32'd1);

      // Sequential fill of all 16 frames, then 16 single-cycle hits.
      do_reset();
      for (int i = 0; i < 16; i++) access(32'(i * 4), 0, 1'b0, "seq_fill");
      for (int i = 0; i < 16; i++) access(32'(i * 4), 0, 1'b1, "seq_hit");
      #1;
      check("seq_miss_cnt", miss_count, 32'd16);
      check("seq_hit_cnt", hit_count, 32'd16);

      // Two addresses on index 0 evict each other every time.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         access(32'h40, 0, 1'b0, "conf_a");
         access(32'h0, 0, 1'b0, "conf_b");
      end
      #1;
      check("conf_miss_cnt", miss_count, 32'd8);
      check("conf_hit_cnt", hit_count, 32'd0);

      // Redirect mid-refill: 0x100 misses, address moves to 0x200 on cycle 3.
      do_reset();
      imemREN  = 1'b1;
      imemaddr = 32'h100;
      iwait    = 1'b1;
      #1;
      check("redir_miss", {31'h0, ihit}, 32'h0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         if (c == 3) imemaddr = 32'h200;
         iwait = (c <= 5);
         #1;
         check("redir_iren", {31'h0, iREN}, 32'h1);
         check("redir_iaddr", iaddr, (c >= 3) ? 32'h200 : 32'h100);
      end
      @(negedge CLK);
      iwait = 1'b1;
      #1;
      check("redir_hit200", {31'h0, ihit}, 32'h1);
      check("redir_data200", imemload, 32'h2001_2005);
      check("redir_miss_cnt", miss_count, 32'd1);
      access(32'h100, 0, 1'b0, "redir_100");

      // Dropping imemREN in FETCH releases iREN at once and skips the fill.
      imemREN  = 1'b1;
      imemaddr = 32'h8;
      #1;
      check("drop_miss", {31'h0, ihit}, 32'h0);
      @(negedge CLK);
      iwait   = 1'b0;
      imemREN = 1'b0;
      #1;
      check("drop_iren", {31'h0, iREN}, 32'h0);
      @(negedge CLK);
      check("drop_state", {31'h0, state_dbg}, 32'h0);
      access(32'h8, 0, 1'b0, "drop_refetch");

      // Flush of a warm frame, then a flush on the fill edge.
      do_reset();
      access(32'h0, 0, 1'b0, "fl_warm");
      access(32'h0, 0, 1'b1, "fl_warmhit");
      imemREN  = 1'b1;
      imemaddr = 32'h0;
      flush    = 1'b1;
      #1;
      check("fl_forced", {31'h0, ihit}, 32'h0);
      @(negedge CLK);
      flush = 1'b0;
      access(32'h0, 0, 1'b0, "fl_after");
      imemaddr = 32'h4;
      #1;
      check("flf_miss", {31'h0, ihit}, 32'h0);
      @(negedge CLK);
      iwait = 1'b0;
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      iwait = 1'b1;
      #1;
      check("flf_state", {31'h0, state_dbg}, 32'h0);
      check("flf_notvalid", {31'h0, ihit}, 32'h0);
      imemREN = 1'b0;
      @(negedge CLK);

      // Asynchronous reset in the middle of a refill.
      do_reset();
      access(32'h0, 0, 1'b0, "ar_warm0");
      access(32'h4, 0, 1'b0, "ar_warm4");
      imemaddr = 32'h8;
      @(negedge CLK);
      iwait = 1'b1;
      #1;
      check("ar_iren_before", {31'h0, iREN}, 32'h1);
      #2;
      nRST = 1'b0;
      #1;
      check("ar_iren", {31'h0, iREN}, 32'h0);
      check("ar_hits", hit_count, 32'h0);
      check("ar_miss", miss_count, 32'h0);
      check("ar_state", {31'h0, state_dbg}, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
      access(32'h0, 0, 1'b0, "ar_cold0");
      access(32'h4, 0, 1'b0, "ar_cold4");
      access(32'h8, 0, 1'b0, "ar_cold8");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory arbiter. It answers fetch-address lookups in the same cycle on a hit. On a miss it runs a single-word refill from memory. It also keeps hit and miss counters for CPI analysis.

## Interface
Parameters:
- SETS, 16, number of one-word frames; power of two; index width IW = log2(SETS)
- TAGW, 30 - IW, tag width; word address bits [31:2] split into tag [31:2+IW] and index [1+IW:2]

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  imemload valid this cycle; datapath advances its pipeline latches on this
- imemload  out  32  instruction word
- flush  in  1  invalidate all frames (self-modifying code / halt)
- iREN  out  1  memory read request
- iaddr  out  32  memory read address, {imemaddr[31:2], 2'b00}
- iwait  in  1  memory busy; low with iREN high means iload valid
- iload  in  32  memory read data
- hit_count  out  32  saturating count of hits
- miss_count  out  32  saturating count of misses

## Operation
- Storage per frame: valid bit, TAGW tag, 32-bit data. Only the valid bits are reset; tag and data are don't-care when invalid.
- Lookup is combinational: hit = imemREN & valid[idx] & (tag[idx] == addr tag).
- FSM state IDLE:
  - ihit = hit; imemload = data[idx] (0 when ihit low); iREN = 0.
  - On imemREN & ~hit & ~flush, go to FETCH.
- FSM state FETCH:
  - ihit = 0; iREN = 1; iaddr tracks current imemaddr combinationally.
  - When iwait = 0: write valid = 1, tag and data (iload) into the frame at the current index and tag; go to IDLE.
  - If imemREN drops: go to IDLE with no fill. iREN drops the same cycle, combinationally.
- Flush:
  - When flush is high at a clock edge, all valid bits clear and the FSM goes to IDLE.
  - flush takes priority over a simultaneous fill; that fill is discarded.
  - ihit is forced to 0 while flush is high.
- Counters:
  - hit_count increments on every edge with state IDLE & ihit.
  - miss_count increments on every IDLE→FETCH transition.
  - Both saturate at 32'hFFFF_FFFF and are cleared only by nRST.
- A fetch address change mid-FETCH (branch resolved downstream) is legal. The fill uses the address present at the edge where iwait is low.

## Timing
- Reset values:
  - state IDLE, all valid = 0, counters = 0
  - ihit = 0 while imemREN is low; iREN = 0
  - imemload = 0 while ihit is low
- Asynchronous reset mid-FETCH: iREN falls immediately and no frame is written.
- Hit latency: 0 cycles; ihit is asserted in the same cycle imemaddr is presented.
- Miss penalty: 1 cycle to enter FETCH, plus N wait cycles, plus 1 cycle back in IDLE where the lookup now hits.
  - With iwait low on the first FETCH cycle, ihit rises 2 cycles after the miss address appears.
- ihit is never asserted in FETCH, including the fill edge.
- Data presented on a hit is the stored word, never iload.
- Two different addresses mapping to the same index evict each other. The result is a miss every time, with no deadlock.
- Outputs other than the counters are Mealy on imemREN, imemaddr and flush. The counters are registered.

## Test plan
- Reset, then imemREN = 1, addr 0x0000_0000, memory returns 0x2001_0005 with iwait low on the first FETCH cycle.
  - Required: cycle 0 ihit = 0 and FSM → FETCH; cycle 1 iREN = 1 with iaddr = 0; cycle 2 ihit = 1 with imemload = 0x2001_0005.
  - Required: miss_count = 1, hit_count increments from cycle 2.
- Sequential fetch 0x0 to 0x3C (16 words), then refetch 0x0 to 0x3C.
  - Required: 16 misses, then 16 consecutive single-cycle hits; miss_count = 16, hit_count = 16.
- Conflict pair 0x0000_0040 and 0x0000_0000 (both index 0) alternated 4 times.
  - Required: every access misses; miss_count = 8; the data returned always matches the memory model.
- Miss on 0x100 with iwait held high 5 cycles; imemaddr changes to 0x200 on cycle 3.
  - Required: iaddr follows to 0x200; the fill writes tag and data for 0x200 only; a later fetch of 0x100 misses.
- Warm 0x0, assert flush for 1 cycle, then fetch 0x0.
  - Required: miss. A separate case asserts flush on the same edge as iwait = 0; required: frame not valid afterward.
- nRST pulsed low mid-FETCH.
  - Required: iREN = 0 immediately, counters = 0, every previously cached address misses.
